// File: rtl/dqsw_trn_pkg.sv
// Shared types and helpers for the DQSW lane write-leveling trainer.
package dqsw_trn_pkg;

   typedef enum logic [3:0] {
      IDLE   = 4'd0,
      LOAD   = 4'd1,
      CLEAR  = 4'd2,
      SETTLE = 4'd3,
      SAMPLE = 4'd4,
      DECIDE = 4'd5,
      MOVE   = 4'd6,
      DONE   = 4'd7,
      FAIL   = 4'd8
   } state_t;

   localparam int DEF_SETTLE_CYCLES = 8;
   localparam int DEF_SAMPLE_CYCLES = 16;

   // Strictly more than half of the 2*sample_cycles bits; a tie is a zero.
   function automatic logic is_majority(input logic [15:0] ones, input logic [15:0] sample_cycles);
      return (ones > sample_cycles);
   endfunction

endpackage

// File: rtl/dqsw_sample_voter.sv
// Accumulates the popcount of the 2-bit RX_DATA feedback over one tap's sample window.
module dqsw_sample_voter
   import dqsw_trn_pkg::*;
#(
   parameter int CNT_W         = 6,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [1:0]       rx_data,
   output logic [CNT_W-1:0] ones,
   output logic             majority
);

   logic [CNT_W-1:0] ones_r;
   logic [CNT_W-1:0] pop_s;

   always_comb begin
      pop_s = CNT_W'(rx_data[0]) + CNT_W'(rx_data[1]);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ones_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         ones_r <= {CNT_W{1'b0}};
      end else if (en) begin
         ones_r <= ones_r + pop_s;
      end else begin
         ones_r <= ones_r;
      end
   end

   assign ones     = ones_r;
   assign majority = is_majority(16'(ones_r), 16'(SAMPLE_CYCLES));

endmodule

// File: rtl/dqsw_delay_trainer.sv
// DQSW lane write-leveling sequencer: steps the IOD delay line and finds the first 0->1 edge.
// Optional build macro DQSW_EYE_QUAL_EN rejects taps flagged early/late by the eye monitor.
module dqsw_delay_trainer
   import dqsw_trn_pkg::*;
#(
   parameter int MAX_TAPS      = 256,
   parameter int TAP_W         = 8,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int SAMPLE_CYCLES = DEF_SAMPLE_CYCLES,
   parameter int CNT_W         = 6
) (
   input  logic             FAB_CLK,
   input  logic             SYNC_RST,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             fail,
   output logic [TAP_W-1:0] edge_tap,
   output logic             dl_load,
   output logic             dl_move,
   output logic             dl_dir,
   input  logic             dl_oor,
   output logic             em_clear,
   input  logic             em_early,
   input  logic             em_late,
`ifdef DQSW_EYE_QUAL_EN
   output logic [TAP_W-1:0] eye_noise_cnt,
`endif
   input  logic [1:0]       rx_data
);

   state_t           state_r;
   logic [TAP_W-1:0] tap_r;
   logic [TAP_W-1:0] edge_tap_r;
   logic [15:0]      wait_r;
   logic             seen_zero_r;
   logic             busy_r;
   logic             done_r;
   logic             fail_r;
   logic             dl_load_r;
   logic             dl_move_r;
   logic             dl_dir_r;
   logic             em_clear_r;
   logic             noisy_r;
   logic [TAP_W-1:0] noise_cnt_r;

   logic             voter_clear_s;
   logic             voter_en_s;
   logic             majority_s;
   logic [CNT_W-1:0] ones_unused_s;
   logic             tap_noisy_s;
   logic             tap_one_s;
   logic             terminal_s;
   logic             abort_s;

   // Window control for the ones accumulator.
   always_comb begin
      voter_clear_s = (state_r == CLEAR);
      voter_en_s    = (state_r == SAMPLE);
   end

   dqsw_sample_voter #(
      .CNT_W        (CNT_W),
      .SAMPLE_CYCLES(SAMPLE_CYCLES)
   ) u_voter (
      .clk     (FAB_CLK),
      .rst     (SYNC_RST),
      .clear   (voter_clear_s),
      .en      (voter_en_s),
      .rx_data (rx_data),
      .ones    (ones_unused_s),
      .majority(majority_s)
   );

   // Per-tap decision inputs and out-of-range abort qualification.
   always_comb begin
`ifdef DQSW_EYE_QUAL_EN
      tap_noisy_s = noisy_r;
`else
      tap_noisy_s = 1'b0;
`endif
      tap_one_s  = majority_s & ~tap_noisy_s;
      terminal_s = (tap_r == TAP_W'(MAX_TAPS - 1));
      case (state_r)
         IDLE, DONE, FAIL: abort_s = 1'b0;
         default:          abort_s = dl_oor;
      endcase
   end

   // Training FSM with registered status and IOD control pulses.
   always_ff @(posedge FAB_CLK) begin
      if (SYNC_RST) begin
         state_r     <= IDLE;
         tap_r       <= {TAP_W{1'b0}};
         edge_tap_r  <= {TAP_W{1'b0}};
         wait_r      <= 16'd0;
         seen_zero_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         fail_r      <= 1'b0;
         dl_load_r   <= 1'b0;
         dl_move_r   <= 1'b0;
         dl_dir_r    <= 1'b1;
         em_clear_r  <= 1'b0;
         noisy_r     <= 1'b0;
         noise_cnt_r <= {TAP_W{1'b0}};
      end else begin
         done_r     <= 1'b0;
         fail_r     <= 1'b0;
         dl_load_r  <= 1'b0;
         dl_move_r  <= 1'b0;
         em_clear_r <= 1'b0;
         if (abort_s) begin
            state_r <= FAIL;
            fail_r  <= 1'b1;
            busy_r  <= 1'b0;
         end else begin
            case (state_r)
               IDLE: begin
                  if (start) begin
                     state_r     <= LOAD;
                     busy_r      <= 1'b1;
                     tap_r       <= {TAP_W{1'b0}};
                     seen_zero_r <= 1'b0;
                     dl_load_r   <= 1'b1;
                     noise_cnt_r <= {TAP_W{1'b0}};
                  end else begin
                     state_r <= IDLE;
                  end
               end
               LOAD: begin
                  state_r    <= CLEAR;
                  em_clear_r <= 1'b1;
               end
               CLEAR: begin
                  state_r <= SETTLE;
                  wait_r  <= 16'd0;
                  noisy_r <= 1'b0;
               end
               SETTLE: begin
                  if (wait_r == 16'(SETTLE_CYCLES - 1)) begin
                     state_r <= SAMPLE;
                     wait_r  <= 16'd0;
                  end else begin
                     wait_r <= wait_r + 16'd1;
                  end
               end
               SAMPLE: begin
                  if (em_early || em_late) begin
                     noisy_r <= 1'b1;
                  end
                  if (wait_r == 16'(SAMPLE_CYCLES - 1)) begin
                     state_r <= DECIDE;
                     wait_r  <= 16'd0;
                  end else begin
                     wait_r <= wait_r + 16'd1;
                  end
               end
               DECIDE: begin
                  if (tap_one_s && seen_zero_r) begin
                     edge_tap_r <= tap_r;
                     state_r    <= DONE;
                     done_r     <= 1'b1;
                     busy_r     <= 1'b0;
                  end else begin
                     // A noisy tap can never be the edge, but it must not arm the edge search either.
                     if (!tap_one_s && !tap_noisy_s) begin
                        seen_zero_r <= 1'b1;
                     end
                     if (tap_noisy_s && (noise_cnt_r != {TAP_W{1'b1}})) begin
                        noise_cnt_r <= noise_cnt_r + {{(TAP_W-1){1'b0}}, 1'b1};
                     end
                     if (terminal_s) begin
                        state_r <= FAIL;
                        fail_r  <= 1'b1;
                        busy_r  <= 1'b0;
                     end else begin
                        state_r   <= MOVE;
                        dl_move_r <= 1'b1;
                        dl_dir_r  <= 1'b1;
                     end
                  end
               end
               MOVE: begin
                  tap_r      <= tap_r + {{(TAP_W-1){1'b0}}, 1'b1};
                  state_r    <= CLEAR;
                  em_clear_r <= 1'b1;
               end
               DONE: begin
                  state_r <= IDLE;
               end
               FAIL: begin
                  state_r <= IDLE;
               end
               default: begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy     = busy_r;
   assign done     = done_r;
   assign fail     = fail_r;
   assign edge_tap = edge_tap_r;
   assign dl_load  = dl_load_r;
   assign dl_move  = dl_move_r;
   assign dl_dir   = dl_dir_r;
   assign em_clear = em_clear_r;

`ifdef DQSW_EYE_QUAL_EN
   assign eye_noise_cnt = noise_cnt_r;
`else
   logic unused_eye_s;
   assign unused_eye_s = ^{em_early, em_late, noisy_r, noise_cnt_r};
`endif

endmodule

// File: tb/tb_dqsw_delay_trainer.sv
// Directed bench for dqsw_delay_trainer with a tap-indexed IOD model and a result scoreboard.
module tb_dqsw_delay_trainer;

   logic       FAB_CLK;
   logic       SYNC_RST;
   logic       start;
   logic       busy;
   logic       done;
   logic       fail;
   logic [7:0] edge_tap;
   logic       dl_load;
   logic       dl_move;
   logic       dl_dir;
   logic       dl_oor;
   logic       em_clear;
   logic       em_early;
   logic       em_late;
   logic [1:0] rx_data;
`ifdef DQSW_EYE_QUAL_EN
   logic [7:0] eye_noise_cnt;
`endif

   typedef struct {
      bit         exp_done;
      logic [7:0] exp_tap;
      int         exp_moves;
      int         exp_last;
   } exp_t;

   exp_t sb_q[$];
   int   tests = 0;
   int   fails = 0;
   int   scen  = 0;
   int   mtap  = 0;
   int   moves = 0;
   int   loads = 0;
   int   cyc   = 0;
   int   oor_cyc  = 0;
   int   fail_cyc = 0;

   dqsw_delay_trainer dut (
      .FAB_CLK (FAB_CLK),
      .SYNC_RST(SYNC_RST),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .fail    (fail),
      .edge_tap(edge_tap),
      .dl_load (dl_load),
      .dl_move (dl_move),
      .dl_dir  (dl_dir),
      .dl_oor  (dl_oor),
      .em_clear(em_clear),
      .em_early(em_early),
      .em_late (em_late),
`ifdef DQSW_EYE_QUAL_EN
      .eye_noise_cnt(eye_noise_cnt),
`endif
      .rx_data (rx_data)
   );

   initial FAB_CLK = 1'b0;
   always #5 FAB_CLK = ~FAB_CLK;

   function automatic logic [1:0] pat(input int s, input int t);
      case (s)
         0:       return (t >= 41) ? 2'b11 : 2'b00;
         1:       return (t <= 9 || t >= 20) ? 2'b11 : 2'b00;
         3:       return 2'b01;
         5:       return (t >= 30) ? 2'b11 : 2'b00;
         default: return 2'b00;
      endcase
   endfunction

   // IOD model: tracks the tap from load/move pulses and presents per-tap feedback.
   initial begin
      rx_data  = 2'b00;
      dl_oor   = 1'b0;
      em_early = 1'b0;
      em_late  = 1'b0;
      forever begin
         @(negedge FAB_CLK);
         cyc = cyc + 1;
         if (dl_load === 1'b1) begin
            loads = loads + 1;
            mtap  = 0;
         end
         if (dl_move === 1'b1 && dl_dir === 1'b1) begin
            moves = moves + 1;
            mtap  = mtap + 1;
         end
         if (fail === 1'b1) fail_cyc = cyc;
         rx_data = pat(scen, mtap);
         if (scen == 4 && mtap == 5) begin
            if (dl_oor == 1'b0) oor_cyc = cyc;
            dl_oor = 1'b1;
         end else begin
            dl_oor = 1'b0;
         end
         em_late = (scen == 5 && mtap == 30);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"},     {31'd0, busy},     32'd0);
      check({tag, "_done"},     {31'd0, done},     32'd0);
      check({tag, "_fail"},     {31'd0, fail},     32'd0);
      check({tag, "_dl_load"},  {31'd0, dl_load},  32'd0);
      check({tag, "_dl_move"},  {31'd0, dl_move},  32'd0);
      check({tag, "_em_clear"}, {31'd0, em_clear}, 32'd0);
      check({tag, "_dl_dir"},   {31'd0, dl_dir},   32'd1);
      check({tag, "_edge_tap"}, {24'd0, edge_tap}, 32'd0);
   endtask

   task automatic run(input int s, input bit exp_done, input logic [7:0] exp_tap,
                      input int exp_moves, input int exp_last, input int restart_at);
      exp_t e;
      bit   got;
      scen  = s;
      moves = 0;
      loads = 0;
      e.exp_done  = exp_done;
      e.exp_tap   = exp_tap;
      e.exp_moves = exp_moves;
      e.exp_last  = exp_last;
      sb_q.push_back(e);
      start = 1'b1;
      @(negedge FAB_CLK);
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("load_pulse", {31'd0, dl_load}, 32'd1);
      got = 1'b0;
      for (int i = 0; i < 9000 && !got; i++) begin
         @(negedge FAB_CLK);
         start = (restart_at > 0 && i == restart_at) ? 1'b1 : 1'b0;
         if (done === 1'b1 || fail === 1'b1) got = 1'b1;
      end
      start = 1'b0;
      check("timeout", {31'd0, got}, 32'd1);
      e = sb_q.pop_front();
      check("done", {31'd0, done}, {31'd0, e.exp_done});
      check("fail", {31'd0, fail}, {31'd0, !e.exp_done});
      check("edge_tap", {24'd0, edge_tap}, {24'd0, e.exp_tap});
      check("move_count", moves, e.exp_moves);
      check("load_count", loads, 32'd1);
      check("busy_at_end", {31'd0, busy}, 32'd0);
      check("model_tap", mtap, e.exp_last);
      @(negedge FAB_CLK);
      check("pulse_width", {31'd0, done | fail}, 32'd0);
   endtask

   initial begin
      SYNC_RST = 1'b1;
      start    = 1'b0;
      repeat (3) @(negedge FAB_CLK);
      check_reset_vals("reset");
      SYNC_RST = 1'b0;

      // Edge at tap 41 after a run of zeros.
      run(0, 1'b1, 8'd41, 41, 41, 0);
      // Leading ones ignored; edge at tap 20.
      run(1, 1'b1, 8'd20, 20, 20, 0);
      // All zeros: fail at terminal tap, edge_tap keeps previous value.
      run(2, 1'b0, 8'd20, 255, 255, 0);
      // Out of range at tap 5: fail one cycle later, no further moves.
      run(4, 1'b0, 8'd20, 5, 5, 0);
      check("oor_latency", fail_cyc - oor_cyc, 32'd1);
      repeat (30) @(negedge FAB_CLK);
      check("oor_no_more_moves", moves, 32'd5);
      // Tie at every tap is a zero: fail; a second start while busy is ignored.
      run(3, 1'b0, 8'd20, 255, 255, 100);

      // Soft reset during sampling at tap 12, then a fresh run.
      scen  = 0;
      moves = 0;
      loads = 0;
      start = 1'b1;
      @(negedge FAB_CLK);
      start = 1'b0;
      for (int i = 0; i < 2000 && moves < 12; i++) @(negedge FAB_CLK);
      check("reach_tap12", moves, 32'd12);
      repeat (14) @(negedge FAB_CLK);
      SYNC_RST = 1'b1;
      @(negedge FAB_CLK);
      check_reset_vals("midrst");
      SYNC_RST = 1'b0;
      run(0, 1'b1, 8'd41, 41, 41, 0);

`ifdef DQSW_EYE_QUAL_EN
      // Eye monitor flags tap 30, so the edge moves to tap 31.
      run(5, 1'b1, 8'd31, 31, 31, 0);
      check("eye_noise_cnt", {24'd0, eye_noise_cnt}, 32'd1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
